// File: rtl/multi_delay_lif_neuron.sv
// Leaky integrate-and-fire neuron with one programmable delay line per synapse.
// Time advances only on steps (enable & delay_tick); the spike output is a one-cycle registered pulse.
module multi_delay_lif_neuron #(
  parameter int M  = 4,
  parameter int W  = 8,
  parameter int P  = 12,
  parameter int D  = 8,
  parameter int DB = $clog2(D)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              delay_tick,
  input  logic [M-1:0]      input_spikes,
  input  logic [M*W-1:0]    weights,
  input  logic [M*DB-1:0]   delay_values,
  input  logic [M-1:0]      delay_en,
  input  logic [P-1:0]      threshold,
  input  logic [P-1:0]      decay,
  input  logic [7:0]        refractory_period,
  input  logic              reset_mode,
  output logic [M-1:0]      delayed_spikes_out,
  output logic [P-1:0]      membrane_potential_out,
  output logic              refractory_active,
  output logic              spike_out
);

  localparam int AW = P + W + $clog2(M) + 1;
  localparam logic signed [AW-1:0] V_MAX = {{(AW-P){1'b0}}, {P{1'b1}}};

  typedef enum logic {INTEGRATE = 1'b0, REFRACTORY = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [M-1:0][D-1:0]    sr_q;
  logic [P-1:0]           v_q;
  logic [7:0]             cnt_q;
  logic                   spike_q;

  logic                   step;
  logic signed [AW-1:0]   syn_sum;
  logic signed [AW-1:0]   total;
  logic [P-1:0]           leak;
  logic [P-1:0]           v_next;
  logic                   fire;

  assign step = enable & delay_tick;

  // A delay of d taps sr[d-1], which holds the spike captured d steps ago.
  always_comb begin
    logic [DB-1:0] dv;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    delayed_spikes_out = '0;
    dv                 = '0;
    for (int i = 0; i < M; i++) begin
      dv = delay_values[i*DB +: DB];
      if (int'(dv) > D - 1) dv = DB'(D - 1);
      if (!delay_en[i] || dv == '0) delayed_spikes_out[i] = input_spikes[i];
      else                          delayed_spikes_out[i] = sr_q[i][dv - DB'(1)];
    end
  end

  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < M; i++) begin
      if (delayed_spikes_out[i]) syn_sum = syn_sum + AW'($signed(weights[i*W +: W]));
    end
    leak  = (v_q > decay) ? v_q - decay : '0;
    total = $signed({{(AW-P){1'b0}}, leak}) + syn_sum;
    if (total < 0)          v_next = '0;
    else if (total > V_MAX) v_next = {P{1'b1}};
    else                    v_next = total[P-1:0];
    fire = (v_next >= threshold);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= INTEGRATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INTEGRATE:  if (step && fire && refractory_period != 8'd0) state_d = REFRACTORY;
      REFRACTORY: if (step && cnt_q <= 8'd1)                     state_d = INTEGRATE;
      default:    state_d = INTEGRATE;
    endcase
  end

  always_comb begin
    refractory_active = (state_q == REFRACTORY);
  end

  // NOTE: the delay lines are plain flops, not RAM, so they are cleared by reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      spike_q <= 1'b0;
      if (step) begin
        for (int i = 0; i < M; i++) sr_q[i] <= {sr_q[i][D-2:0], input_spikes[i]};
        if (state_q == INTEGRATE) begin
          if (fire) begin
            spike_q <= 1'b1;
            v_q     <= reset_mode ? v_next - threshold : '0;
            cnt_q   <= refractory_period;
          end else begin
            v_q <= v_next;
          end
        end else begin
          cnt_q <= cnt_q - 8'd1;
        end
      end
    end
  end

  assign membrane_potential_out = v_q;
  assign spike_out              = spike_q;

endmodule

// File: tb/tb_multi_delay_lif_neuron.sv
// Bench for multi_delay_lif_neuron: directed scenarios with literal expectations, then
// randomized stimulus compared every cycle against a step-level behavioural model.
module tb_multi_delay_lif_neuron;

  localparam int M  = 4;
  localparam int W  = 8;
  localparam int P  = 12;
  localparam int D  = 8;
  localparam int DB = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              delay_tick;
  logic [M-1:0]      input_spikes;
  logic [M*W-1:0]    weights;
  logic [M*DB-1:0]   delay_values;
  logic [M-1:0]      delay_en;
  logic [P-1:0]      threshold;
  logic [P-1:0]      decay;
  logic [7:0]        refractory_period;
  logic              reset_mode;
  logic [M-1:0]      delayed_spikes_out;
  logic [P-1:0]      membrane_potential_out;
  logic              refractory_active;
  logic              spike_out;

  multi_delay_lif_neuron #(.M(M), .W(W), .P(P), .D(D), .DB(DB)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .delay_tick             (delay_tick),
    .input_spikes           (input_spikes),
    .weights                (weights),
    .delay_values           (delay_values),
    .delay_en               (delay_en),
    .threshold              (threshold),
    .decay                  (decay),
    .refractory_period      (refractory_period),
    .reset_mode             (reset_mode),
    .delayed_spikes_out     (delayed_spikes_out),
    .membrane_potential_out (membrane_potential_out),
    .refractory_active      (refractory_active),
    .spike_out              (spike_out)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: hist[i][k] is the spike of input i seen k steps ago.
  bit m_hist [M][D+1];
  int m_v;
  int m_cnt;
  bit m_refr;
  bit m_spk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_dly(int i);
    int d;
    d = int'(delay_values[i*DB +: DB]);
    if (d >= D) d = D - 1;
    if (!delay_en[i] || d == 0) return input_spikes[i];
    return m_hist[i][d];
  endfunction

  task automatic model_update();
    bit d[M];
    int s, l, vn;
    if (reset) begin
      for (int i = 0; i < M; i++) for (int k = 0; k <= D; k++) m_hist[i][k] = 1'b0;
      m_v = 0; m_cnt = 0; m_refr = 1'b0; m_spk = 1'b0;
    end else if (enable && delay_tick) begin
      for (int i = 0; i < M; i++) d[i] = m_dly(i);
      m_spk = 1'b0;
      if (!m_refr) begin
        s = 0;
        for (int i = 0; i < M; i++) if (d[i]) s += int'($signed(weights[i*W +: W]));
        l  = (m_v > int'(decay)) ? m_v - int'(decay) : 0;
        vn = l + s;
        if (vn < 0) vn = 0;
        if (vn > (1 << P) - 1) vn = (1 << P) - 1;
        if (vn >= int'(threshold)) begin
          m_spk = 1'b1;
          m_v   = reset_mode ? vn - int'(threshold) : 0;
          if (refractory_period != 0) begin
            m_refr = 1'b1;
            m_cnt  = int'(refractory_period);
          end
        end else begin
          m_v = vn;
        end
      end else begin
        if (m_cnt == 1) m_refr = 1'b0;
        m_cnt--;
      end
      for (int i = 0; i < M; i++) begin
        for (int k = D; k >= 2; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][1] = input_spikes[i];
      end
    end else begin
      m_spk = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [M-1:0] exp_d;
    for (int i = 0; i < M; i++) exp_d[i] = m_dly(i);
    check("delayed_spikes", delayed_spikes_out, exp_d);
    check("potential", membrane_potential_out, m_v);
    check("refractory", refractory_active, m_refr);
    check("spike", spike_out, m_spk);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic step(input logic [M-1:0] sp);
    input_spikes = sp; enable = 1'b1; delay_tick = 1'b1;
    cycle();
    input_spikes = '0; delay_tick = 1'b0;
  endtask

  task automatic idle();
    delay_tick = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic set_w(input int i, input int val);
    weights[i*W +: W] = W'(val);
  endtask

  task automatic config_neuron(input int w0, input int w1, input int thr, input int dec,
                               input int rp, input bit mode);
    weights = '0; set_w(0, w0); set_w(1, w1);
    delay_en = '0; delay_values = '0;
    threshold = P'(thr); decay = P'(dec); refractory_period = 8'(rp); reset_mode = mode;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; enable = 1'b1; delay_tick = 1'b0; input_spikes = '0;
    weights = '0; delay_values = '0; delay_en = '0;
    threshold = '0; decay = '0; refractory_period = '0; reset_mode = 1'b0;

    do_reset();
    check("rst_v", membrane_potential_out, 0);
    check("rst_refr", refractory_active, 0);
    check("rst_spike", spike_out, 0);

    // Delay of 3 steps on input 0
    config_neuron(10, 0, 100, 0, 0, 1'b0);
    delay_en = 4'b0001; delay_values[0 +: DB] = 3'd3;
    do_reset();
    step(4'b0001); check("dly_v_k", membrane_potential_out, 0);
    step(4'b0000); check("dly_v_k1", membrane_potential_out, 0);
    step(4'b0000); check("dly_v_k2", membrane_potential_out, 0);
    check("dly_tap_out", delayed_spikes_out[0], 1);
    step(4'b0000); check("dly_v_k3", membrane_potential_out, 10);
    check("dly_no_spike", spike_out, 0);

    // Enable low for 5 ticks in the middle of the delay
    do_reset();
    step(4'b0001); step(4'b0000);
    enable = 1'b0; delay_tick = 1'b1; input_spikes = 4'b0001;
    repeat (5) cycle();
    check("hold_v", membrane_potential_out, 0);
    enable = 1'b1; input_spikes = '0; delay_tick = 1'b0;
    step(4'b0000); check("hold_v_k2", membrane_potential_out, 0);
    step(4'b0000); check("hold_v_k3", membrane_potential_out, 10);
    repeat (4) step(4'b0000);
    check("hold_no_capture", membrane_potential_out, 10);

    // Fire with zero reset, refractory of 2 steps; period change mid-count ignored
    config_neuron(60, 60, 100, 5, 2, 1'b0);
    do_reset();
    step(4'b0011);
    check("fire0_spike", spike_out, 1);
    check("fire0_v", membrane_potential_out, 0);
    check("fire0_refr", refractory_active, 1);
    refractory_period = 8'd7;
    idle(); check("fire0_pulse_one_cycle", spike_out, 0);
    step(4'b0011); check("fire0_ign1_refr", refractory_active, 1);
    check("fire0_ign1_v", membrane_potential_out, 0);
    step(4'b0011); check("fire0_ign2_refr", refractory_active, 0);
    check("fire0_ign2_v", membrane_potential_out, 0);
    step(4'b0001); check("fire0_resume_v", membrane_potential_out, 60);

    // Subtract mode, then floor cases
    config_neuron(60, 60, 100, 5, 2, 1'b1);
    do_reset();
    step(4'b0011);
    check("fire1_spike", spike_out, 1);
    check("fire1_v", membrane_potential_out, 20);
    step(4'b0011); step(4'b0011);
    check("fire1_hold_v", membrane_potential_out, 20);
    check("fire1_refr_done", refractory_active, 0);
    decay = '0; set_w(0, -50);
    step(4'b0001); check("floor_neg", membrane_potential_out, 0);
    set_w(0, 3);
    step(4'b0001); check("floor_v3", membrane_potential_out, 3);
    decay = P'(10);
    step(4'b0000); check("floor_decay", membrane_potential_out, 0);

    // Saturation
    config_neuron(127, 127, 4095, 0, 0, 1'b0);
    set_w(2, 127); set_w(3, 127);
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      step(4'b1111);
      check("sat_ramp", membrane_potential_out, 508 * n);
    end
    step(4'b1111);
    check("sat_fire", spike_out, 1);
    check("sat_v", membrane_potential_out, 0);

    // Reset during refractory wins over enable/step
    config_neuron(60, 60, 100, 0, 5, 1'b0);
    do_reset();
    step(4'b0011);
    check("rr_refr_before", refractory_active, 1);
    delay_en = 4'b1111; delay_values = {4{3'd1}};
    input_spikes = 4'b1111; enable = 1'b1; delay_tick = 1'b1;
    do_reset();
    check("rr_refr", refractory_active, 0);
    check("rr_v", membrane_potential_out, 0);
    check("rr_dly", delayed_spikes_out, 0);
    check("rr_spike", spike_out, 0);
    input_spikes = '0; delay_tick = 1'b0;

    // Randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      if (c % 40 == 0) begin
        for (int i = 0; i < M; i++) set_w(i, int'($urandom_range(0, 157)) - 30);
        r = $urandom; delay_values = r[M*DB-1:0];
        r = $urandom; delay_en = r[M-1:0];
        threshold = ($urandom_range(0, 9) == 0) ? '0 : P'($urandom_range(1, 600));
        decay = P'($urandom_range(0, 30));
        refractory_period = 8'($urandom_range(0, 6));
        reset_mode = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 19) == 0) refractory_period = 8'($urandom_range(0, 6));
      r = $urandom; input_spikes = r[M-1:0];
      enable     = ($urandom_range(0, 9) != 0);
      delay_tick = ($urandom_range(0, 2) != 0);
      reset      = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
